// File: rtl/hazard_if.sv
// -----------------------------------------------------------------------------
// hazard_if -- bundle of every pipeline-facing signal of the hazard controller.
//
//   master : pipeline side. It drives register numbers, write enables, load,
//            branch, memory and divider status, and fault_clear. It receives
//            the forwarding selects, stall/flush controls, mem_fault and
//            stall_cnt.
//   slave  : hazard controller side, with the opposite directions.
//
//   CNT_WIDTH : width of stall_cnt. It must match the controller's CNT_WIDTH.
// -----------------------------------------------------------------------------
interface hazard_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           Rs1D, Rs2D;
    logic [4:0]           Rs1E, Rs2E, RdE;
    logic [4:0]           RdM, RdW;
    logic                 RegWriteM, RegWriteW;
    logic                 LoadE;
    logic                 PCSrcE;
    logic                 mem_req_M, mem_ack;
    logic                 div_busy_E, div_done;
    logic                 fault_clear;

    logic [1:0]           ForwardAE, ForwardBE;
    logic                 StallF, StallD, StallE, StallM;
    logic                 FlushD, FlushE, FlushM, FlushW;
    logic                 mem_fault;
    logic [CNT_WIDTH-1:0] stall_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE,
        output mem_req_M, mem_ack, div_busy_E, div_done, fault_clear,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushM, FlushW,
        input  mem_fault, stall_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE,
        input  mem_req_M, mem_ack, div_busy_E, div_done, fault_clear,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushM, FlushW,
        output mem_fault, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- hazard unit for a five-stage pipeline. It has these functions:
//   * Operand forwarding from the Memory and Writeback stages.
//   * Load-use stall.
//   * Stall while data memory has not acknowledged. A watchdog moves the unit
//     to a sticky FAULT state on timeout.
//   * Stall while a multi-cycle divide is busy.
//   * Branch flush.
//   * Saturating count of front-end stall cycles.
//
// Ports:
//   clk    : single clock. All state updates on the rising edge.
//   reset  : asynchronous, active low.
//   hz     : hazard_if.slave, which carries all pipeline inputs and outputs.
//
// Parameters:
//   MEM_TIMEOUT : number of MEM_WAIT cycles without mem_ack before FAULT.
//   CNT_WIDTH   : width of stall_cnt.
//
// Stall and flush outputs are combinational from the current state and the
// inputs. A stall therefore asserts in the same cycle as its cause.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  hz
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_pend, memstall, divstall, lw_hazard, lwstall;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_w;

    // Forwarding. The Memory stage holds the newer value, so it wins.
    always_comb begin
        hz.ForwardAE = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
            hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
            hz.ForwardAE = 2'b01;

        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
            hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
            hz.ForwardBE = 2'b01;
    end

    // Stall causes, highest priority first.
    assign mem_pend  = hz.mem_req_M & ~hz.mem_ack;
    assign memstall  = mem_pend | (state_q == FAULT);
    assign divstall  = hz.div_busy_E & ~hz.div_done & ~memstall;
    assign lw_hazard = hz.LoadE & (hz.RdE != 5'd0) &
                       ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));
    assign lwstall   = lw_hazard & ~memstall & ~divstall;

    // A taken branch waiting in a held Execute stage keeps PCSrcE high.
    // Its flush therefore fires on the first cycle after the stall ends.
    // No extra state is needed to remember it.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (memstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;  // bubble into Writeback while Memory is frozen
        end else if (divstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;  // bubble into Memory while Execute is frozen
        end else begin
            stall_f = lwstall;
            stall_d = lwstall;
            flush_d = hz.PCSrcE;
            flush_e = hz.PCSrcE | lwstall;
        end
    end

    assign hz.StallF = stall_f;
    assign hz.StallD = stall_d;
    assign hz.StallE = stall_e;
    assign hz.StallM = stall_m;
    assign hz.FlushD = flush_d;
    assign hz.FlushE = flush_e;
    assign hz.FlushM = flush_m;
    assign hz.FlushW = flush_w;

    // Next-state logic. The memory condition has priority over the divide.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (mem_pend) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end else if (hz.div_busy_E && !hz.div_done) begin
                    state_d = DIV_WAIT;
                end
            end
            MEM_WAIT: begin
                // An ack on the final wait cycle beats the timeout.
                if (hz.mem_ack)
                    state_d = IDLE;
                else if (wait_q == WAIT_LAST)
                    state_d = FAULT;
                else
                    wait_d = wait_q + WAIT_W'(1);
            end
            DIV_WAIT: begin
                if (mem_pend) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end else if (hz.div_done) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (hz.fault_clear)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && stall_cnt_q != {CNT_WIDTH{1'b1}})
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.mem_fault = (state_q == FAULT);
    assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Control vector layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LW   = 8'b1100_0100;
    localparam logic [7:0] C_MEM  = 8'b1111_0001;
    localparam logic [7:0] C_DIV  = 8'b1110_0010;
    localparam logic [7:0] C_BR   = 8'b0000_1100;
    localparam logic [1:0] S_IDLE = 2'd0, S_MW = 2'd1, S_DW = 2'd2, S_FLT = 2'd3;

    hazard_if #(.CNT_WIDTH(16)) hz ();
    hazard_if #(.CNT_WIDTH(2))  hz2 ();

    // The second instance sees the same stimulus and has a 2-bit counter.
    // It is used to exercise stall_cnt saturation.
    assign hz2.Rs1D = hz.Rs1D;             assign hz2.Rs2D = hz.Rs2D;
    assign hz2.Rs1E = hz.Rs1E;             assign hz2.Rs2E = hz.Rs2E;
    assign hz2.RdE = hz.RdE;               assign hz2.RdM = hz.RdM;
    assign hz2.RdW = hz.RdW;               assign hz2.RegWriteM = hz.RegWriteM;
    assign hz2.RegWriteW = hz.RegWriteW;   assign hz2.LoadE = hz.LoadE;
    assign hz2.PCSrcE = hz.PCSrcE;         assign hz2.mem_req_M = hz.mem_req_M;
    assign hz2.mem_ack = hz.mem_ack;       assign hz2.div_busy_E = hz.div_busy_E;
    assign hz2.div_done = hz.div_done;     assign hz2.fault_clear = hz.fault_clear;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .hz(hz)
    );
    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .hz(hz2)
    );

    typedef struct {
        string      tag;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] ctl;
        logic [1:0] st;
        logic       mf;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic clear_inputs();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
        hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0; hz.LoadE = 0; hz.PCSrcE = 0;
        hz.mem_req_M = 0; hz.mem_ack = 0; hz.div_busy_E = 0; hz.div_done = 0;
        hz.fault_clear = 0;
    endtask

    task automatic push_exp(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [7:0] ctl, input logic [1:0] st, input logic mf,
                            input int cnt);
        exp_t e;
        e.tag = tag; e.fa = fa; e.fb = fb; e.ctl = ctl; e.st = st; e.mf = mf; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic check_one();
        exp_t e;
        logic [7:0] ctl_obs;
        int sat;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        ctl_obs = {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                   hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};
        sat = (e.cnt > 3) ? 3 : e.cnt;
        chk(e.tag, "ForwardAE", 32'(hz.ForwardAE), 32'(e.fa));
        chk(e.tag, "ForwardBE", 32'(hz.ForwardBE), 32'(e.fb));
        chk(e.tag, "ctl",       32'(ctl_obs),      32'(e.ctl));
        chk(e.tag, "state",     32'(dut.state_q),  32'(e.st));
        chk(e.tag, "mem_fault", 32'(hz.mem_fault), 32'(e.mf));
        chk(e.tag, "stall_cnt", 32'(hz.stall_cnt), 32'(e.cnt));
        chk(e.tag, "sat_cnt",   32'(hz2.stall_cnt), 32'(sat));
        $display("step %-10s fa=%b fb=%b ctl=%b st=%0d mf=%b cnt=%0d sat=%0d",
                 e.tag, hz.ForwardAE, hz.ForwardBE, ctl_obs, dut.state_q,
                 hz.mem_fault, hz.stall_cnt, hz2.stall_cnt);
    endtask

    // One clock cycle. The inputs are already set. The expectation is pushed,
    // compared at the falling edge, and then the rising edge is passed.
    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [7:0] ctl, input logic [1:0] st, input logic mf,
                        input int cnt);
        push_exp(tag, fa, fb, ctl, st, mf, cnt);
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stall outputs must follow the inputs while reset is held low.
        clear_inputs();
        reset = 1'b0;
        hz.LoadE = 1; hz.RdE = 7; hz.Rs2D = 7;
        #3;
        push_exp("rst_lw", 2'b00, 2'b00, C_LW, S_IDLE, 1'b0, 0);
        check_one();
        @(negedge clk);
        clear_inputs();
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Forwarding.
        hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs1E = 5; hz.Rs2E = 5;
        step("fwd_mprio", 2'b10, 2'b10, C_NONE, S_IDLE, 1'b0, 0);
        hz.RdM = 0;
        step("fwd_rdm0", 2'b01, 2'b01, C_NONE, S_IDLE, 1'b0, 0);
        hz.RdM = 3; hz.Rs1E = 3; hz.RdW = 4; hz.Rs2E = 4;
        step("fwd_split", 2'b10, 2'b01, C_NONE, S_IDLE, 1'b0, 0);
        hz.RegWriteM = 0; hz.RdW = 0; hz.Rs2E = 0;
        step("fwd_none", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 0);
        clear_inputs();

        // Load-use stall for one cycle. The counter then moves by one.
        hz.LoadE = 1; hz.RdE = 7; hz.Rs2D = 7;
        step("lw", 2'b00, 2'b00, C_LW, S_IDLE, 1'b0, 0);
        clear_inputs();
        step("lw_after", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 1);
        hz.LoadE = 1; hz.RdE = 0; hz.Rs1D = 0;
        step("lw_x0", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 1);
        clear_inputs();
        hz.PCSrcE = 1;
        step("branch", 2'b00, 2'b00, C_BR, S_IDLE, 1'b0, 1);
        clear_inputs();

        // Memory wait for three cycles, then an ack.
        hz.mem_req_M = 1;
        step("mw1", 2'b00, 2'b00, C_MEM, S_IDLE, 1'b0, 1);
        step("mw2", 2'b00, 2'b00, C_MEM, S_MW, 1'b0, 2);
        step("mw3", 2'b00, 2'b00, C_MEM, S_MW, 1'b0, 3);
        hz.mem_ack = 1;
        step("mw_ack", 2'b00, 2'b00, C_NONE, S_MW, 1'b0, 4);
        clear_inputs();
        step("mw_idle", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 4);

        // An ack on the last allowed wait cycle beats the timeout.
        hz.mem_req_M = 1;
        step("to_c1", 2'b00, 2'b00, C_MEM, S_IDLE, 1'b0, 4);
        for (int i = 0; i < 3; i++)
            step("to_w", 2'b00, 2'b00, C_MEM, S_MW, 1'b0, 5 + i);
        hz.mem_ack = 1;
        step("to_ack", 2'b00, 2'b00, C_NONE, S_MW, 1'b0, 8);
        clear_inputs();
        step("to_idle", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 8);

        // Timeout goes to FAULT. FAULT holds the stalls and defers the branch
        // flush until fault_clear releases it.
        hz.mem_req_M = 1;
        step("flt_c1", 2'b00, 2'b00, C_MEM, S_IDLE, 1'b0, 8);
        for (int i = 0; i < 4; i++)
            step("flt_w", 2'b00, 2'b00, C_MEM, S_MW, 1'b0, 9 + i);
        hz.mem_req_M = 0;
        step("flt_hold", 2'b00, 2'b00, C_MEM, S_FLT, 1'b1, 13);
        hz.PCSrcE = 1;
        step("flt_br", 2'b00, 2'b00, C_MEM, S_FLT, 1'b1, 14);
        hz.fault_clear = 1;
        step("flt_clr", 2'b00, 2'b00, C_MEM, S_FLT, 1'b1, 15);
        hz.fault_clear = 0;
        step("flt_brout", 2'b00, 2'b00, C_BR, S_IDLE, 1'b0, 16);
        clear_inputs();

        // Divide busy for five cycles with a taken branch. The branch flush
        // must appear on the div_done cycle.
        hz.div_busy_E = 1; hz.PCSrcE = 1;
        step("div1", 2'b00, 2'b00, C_DIV, S_IDLE, 1'b0, 16);
        for (int i = 0; i < 4; i++)
            step("div_w", 2'b00, 2'b00, C_DIV, S_DW, 1'b0, 17 + i);
        hz.div_done = 1;
        step("div_done", 2'b00, 2'b00, C_BR, S_DW, 1'b0, 21);
        clear_inputs();
        step("div_idle", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 21);

        // A memory stall in DIV_WAIT takes priority and moves to MEM_WAIT.
        hz.div_busy_E = 1;
        step("dm1", 2'b00, 2'b00, C_DIV, S_IDLE, 1'b0, 21);
        hz.mem_req_M = 1;
        step("dm_mem", 2'b00, 2'b00, C_MEM, S_DW, 1'b0, 22);
        hz.mem_ack = 1;
        step("dm_ack", 2'b00, 2'b00, C_DIV, S_MW, 1'b0, 23);
        clear_inputs();
        step("dm_idle", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 24);

        // Enter FAULT, then assert reset between clock edges.
        hz.mem_req_M = 1;
        step("rf_c1", 2'b00, 2'b00, C_MEM, S_IDLE, 1'b0, 24);
        for (int i = 0; i < 4; i++)
            step("rf_w", 2'b00, 2'b00, C_MEM, S_MW, 1'b0, 25 + i);
        hz.mem_req_M = 0;
        step("rf_flt", 2'b00, 2'b00, C_MEM, S_FLT, 1'b1, 29);
        reset = 1'b0;
        #1;
        push_exp("rf_async", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 0);
        check_one();
        #2 reset = 1'b1;
        step("rf_post", 2'b00, 2'b00, C_NONE, S_IDLE, 1'b0, 0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_left observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64: maximum data-memory wait cycles before a fault is declared.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the stall-cycle performance counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; the module is in reset while reset=0.
REQ-005 Rs1D, Rs2D  input  5 each  source registers of the instruction in Decode.
REQ-006 Rs1E, Rs2E, RdE  input  5 each  source and destination registers in Execute.
REQ-007 RdM, RdW  input  5 each  destination registers in Memory and Writeback.
REQ-008 RegWriteM, RegWriteW  input  1 each  register-write enables in Memory and Writeback.
REQ-009 LoadE  input  1  the instruction in Execute is a load.
REQ-010 PCSrcE  input  1  branch or jump taken in Execute.
REQ-011 mem_req_M, mem_ack  input  1 each  data-memory request in Memory, and the memory's ready/acknowledge.
REQ-012 div_busy_E, div_done  input  1 each  multi-cycle divide in Execute, and its completion pulse.
REQ-013 fault_clear  input  1  synchronous release from FAULT.
REQ-014 ForwardAE, ForwardBE  output  2 each  operand select: 00 register file, 10 Memory result, 01 Writeback result.
REQ-015 StallF, StallD, StallE, StallM  output  1 each  hold-enable deassert for the pipeline registers (enable = ~Stall).
REQ-016 FlushD, FlushE, FlushM, FlushW  output  1 each  synchronous clear for the pipeline registers.
REQ-017 mem_fault  output  1  sticky, high while in FAULT.
REQ-018 stall_cnt  output  CNT_WIDTH  count of cycles with StallF=1, saturating.

Function
REQ-019 Forwarding SHALL be combinational: ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. ForwardBE is the same using Rs2E.
REQ-020 FSM states SHALL be IDLE, MEM_WAIT, DIV_WAIT and FAULT, encoded in 2 bits; the reset state is IDLE.
REQ-021 IDLE->MEM_WAIT on mem_req_M & ~mem_ack; IDLE->DIV_WAIT on div_busy_E & ~div_done & ~(mem_req_M & ~mem_ack); memory has priority.
REQ-022 MEM_WAIT->IDLE on mem_ack; MEM_WAIT->FAULT when the wait counter reaches MEM_TIMEOUT-1 without mem_ack; mem_ack in that same cycle wins, returning to IDLE.
REQ-023 DIV_WAIT->IDLE on div_done; DIV_WAIT->MEM_WAIT on mem_req_M & ~mem_ack.
REQ-024 FAULT->IDLE only on fault_clear=1.
REQ-025 The wait counter SHALL clear on entry to MEM_WAIT and increment once per MEM_WAIT cycle.
REQ-026 memstall = (mem_req_M & ~mem_ack) | state==FAULT.
REQ-027 When memstall=1: StallF, StallD, StallE and StallM =1; FlushW=1; all other flushes =0.
REQ-028 divstall = div_busy_E & ~div_done & ~memstall.
REQ-029 When divstall=1: StallF, StallD and StallE =1; FlushM=1; FlushD and FlushE =0.
REQ-030 lwstall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D), effective only when memstall=0 and divstall=0.
REQ-031 When lwstall=1: StallF and StallD =1; FlushE=1.
REQ-032 When no stall is active: FlushD=PCSrcE and FlushE=PCSrcE|lwstall. A branch flush SHALL be deferred, never dropped, while Execute is held.
REQ-033 The stall equations in REQ-026 to REQ-032 are combinational from state and inputs, so a stall asserts in the same cycle as its cause; the only registered elements are state, the wait counter and stall_cnt.
REQ-034 stall_cnt SHALL increment on every cycle with StallF=1 and hold at all-ones.

Reset
REQ-035 While reset=0: state=IDLE, wait counter=0, stall_cnt=0, mem_fault=0; stall and flush outputs follow the inputs per REQ-027 to REQ-032 with state=IDLE.
REQ-036 Reset asserted mid-MEM_WAIT or mid-FAULT SHALL return the FSM to IDLE immediately, without waiting for a clock edge.

Verification
REQ-037 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10 (Memory has priority). With RdM=0 instead -> ForwardAE=01.
REQ-038 LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, and stall_cnt increments by 1.
REQ-039 mem_req_M=1 with mem_ack low for 3 cycles -> Stall F/D/E/M=1 and FlushW=1 for 3 cycles; state returns to IDLE on the ack cycle.
REQ-040 MEM_TIMEOUT=4, mem_ack held 0 -> FAULT after 4 wait cycles with mem_fault=1 and stalls held; fault_clear=1 -> IDLE.
REQ-041 div_busy_E=1 for 5 cycles with PCSrcE=1 -> FlushD=0 and FlushM=1 during the stall; on div_done, FlushD=FlushE=1.
REQ-042 reset=0 asserted during FAULT with stall_cnt=20 -> state=IDLE, stall_cnt=0 and mem_fault=0 immediately.
